// File: rtl/adder_tree_pkg.sv
// Shared constants and width helpers for the adder tree and its input packer.
package adder_tree_pkg;

  // Largest lane count the tree (and therefore the packer) supports.
  localparam int unsigned MAX_INPUTS = 32;

  // Width needed to hold a lane count 0..n; also used by the tree's sum-width math.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  // Packer fill state: EMPTY means wr_idx == 0, FILL means 0 < wr_idx < NUM_INPUTS.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FILL  = 1'b1
  } pack_state_e;

endpackage

// File: rtl/adder_tree_packer.sv
// Serial-to-parallel lane packer feeding the adder tree: collects one operand
// per accepted beat into NUM_INPUTS lanes and emits each closed vector as a
// one-cycle o_valid strobe with unused upper lanes forced to zero.
module adder_tree_packer
  import adder_tree_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = 4,
  parameter int unsigned NUM_INPUTS = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [DATAWIDTH-1:0]                   s_data,
  input  logic                                   s_last,
  input  logic                                   flush,
  output logic                                   o_valid,
  output logic [NUM_INPUTS-1:0][DATAWIDTH-1:0]   o_data,
  output logic [cnt_width(NUM_INPUTS)-1:0]       o_count,
  output logic                                   o_last,
  output logic [CNT_W-1:0]                       vec_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_INPUTS);
  localparam int unsigned CW    = cnt_width(NUM_INPUTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  typedef logic [NUM_INPUTS-1:0][DATAWIDTH-1:0] vec_t;

  pack_state_e          state_q,   state_d;
  logic [IDX_W-1:0]     wr_idx_q,  wr_idx_d;
  vec_t                 fill_q,    fill_d;
  logic                 ready_q,   ready_d;
  logic                 o_valid_q, o_valid_d;
  vec_t                 o_data_q,  o_data_d;
  logic [CW-1:0]        o_count_q, o_count_d;
  logic                 o_last_q,  o_last_d;
  logic [CNT_W-1:0]     vec_cnt_q, vec_cnt_d;

  logic                 accept;
  logic                 closing;
  logic                 lone_flush;
  logic [NUM_INPUTS-1:0] lane_we;
  vec_t                 beat_vec;
  vec_t                 part_vec;

  assign accept     = s_valid & ready_q;
  assign closing    = accept & ((wr_idx_q == LAST_IDX) | s_last | flush);
  assign lone_flush = flush & ~accept & (state_q == ST_FILL);

  // Per-lane write enable decode and the two candidate output vectors:
  // beat_vec includes the closing beat at wr_idx, part_vec is the buffer alone.
  // Lanes at or above the fill point are masked explicitly so the zero-padding
  // does not depend on the buffer having been cleared.
  always_comb begin
    lane_we  = '0;
    beat_vec = '0;
    part_vec = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (IDX_W'(i) == wr_idx_q) begin
        lane_we[i]  = accept;
        beat_vec[i] = s_data;
      end else if (IDX_W'(i) < wr_idx_q) begin
        beat_vec[i] = fill_q[i];
        part_vec[i] = fill_q[i];
      end
    end
  end

  // Next-state: lane fill, emission on a closing beat or a lone flush in FILL.
  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    fill_d    = fill_q;
    ready_d   = 1'b1;
    o_valid_d = 1'b0;
    o_data_d  = o_data_q;
    o_count_d = o_count_q;
    o_last_d  = o_last_q;
    vec_cnt_d = vec_cnt_q;

    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (lane_we[i]) begin
        fill_d[i] = s_data;
      end
    end

    case (state_q)
      ST_EMPTY: begin
        if (closing) begin
          o_valid_d = 1'b1;
          o_data_d  = beat_vec;
          o_count_d = CW'(1);
          o_last_d  = s_last;
          vec_cnt_d = vec_cnt_q + CNT_W'(1);
          fill_d    = '0;
          wr_idx_d  = '0;
          state_d   = ST_EMPTY;
        end else if (accept) begin
          wr_idx_d  = wr_idx_q + IDX_W'(1);
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (closing) begin
          o_valid_d = 1'b1;
          o_data_d  = beat_vec;
          o_count_d = CW'(wr_idx_q) + CW'(1);
          o_last_d  = s_last;
          vec_cnt_d = vec_cnt_q + CNT_W'(1);
          fill_d    = '0;
          wr_idx_d  = '0;
          state_d   = ST_EMPTY;
        end else if (lone_flush) begin
          o_valid_d = 1'b1;
          o_data_d  = part_vec;
          o_count_d = CW'(wr_idx_q);
          o_last_d  = 1'b0;
          vec_cnt_d = vec_cnt_q + CNT_W'(1);
          fill_d    = '0;
          wr_idx_d  = '0;
          state_d   = ST_EMPTY;
        end else if (accept) begin
          wr_idx_d  = wr_idx_q + IDX_W'(1);
          state_d   = ST_FILL;
        end
      end
      default: begin
        fill_d   = '0;
        wr_idx_d = '0;
        state_d  = ST_EMPTY;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_EMPTY;
      wr_idx_q  <= '0;
      fill_q    <= '0;
      ready_q   <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_count_q <= '0;
      o_last_q  <= 1'b0;
      vec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      fill_q    <= fill_d;
      ready_q   <= ready_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_count_q <= o_count_d;
      o_last_q  <= o_last_d;
      vec_cnt_q <= vec_cnt_d;
    end
  end

  assign s_ready = ready_q;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_count = o_count_q;
  assign o_last  = o_last_q;
  assign vec_cnt = vec_cnt_q;

endmodule

// File: tb/tb_adder_tree_packer.sv
// Directed bench for adder_tree_packer with DATAWIDTH=4, NUM_INPUTS=4.
module tb_adder_tree_packer;

  localparam int unsigned DW = 4;
  localparam int unsigned NI = 4;
  localparam int unsigned CW = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   s_valid;
  logic                   s_ready;
  logic [DW-1:0]          s_data;
  logic                   s_last;
  logic                   flush;
  logic                   o_valid;
  logic [NI-1:0][DW-1:0]  o_data;
  logic [2:0]             o_count;
  logic                   o_last;
  logic [CW-1:0]          vec_cnt;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned emits  = 0;

  adder_tree_packer #(
    .DATAWIDTH (DW),
    .NUM_INPUTS(NI),
    .CNT_W     (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .flush  (flush),
    .o_valid(o_valid),
    .o_data (o_data),
    .o_count(o_count),
    .o_last (o_last),
    .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic last, input logic fl);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    flush   = fl;
    cyc();
    s_valid = 1'b0;
    s_last  = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic idle(input logic fl);
    s_valid = 1'b0;
    s_last  = 1'b0;
    flush   = fl;
    cyc();
    flush   = 1'b0;
  endtask

  // Sum the tree would produce from the four lanes.
  function automatic logic [31:0] tree_sum(input logic [NI-1:0][DW-1:0] v);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < NI; k++) s += 32'(v[k]);
    return s;
  endfunction

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; flush = 1'b0;
    cyc(); cyc();

    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data",  32'(o_data),  32'd0);
    chk("rst_o_count", 32'(o_count), 32'd0);
    chk("rst_o_last",  32'(o_last),  32'd0);
    chk("rst_vec_cnt", 32'(vec_cnt), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);

    rst = 1'b1;
    idle(1'b0);
    chk("s_ready_after_rst", 32'(s_ready), 32'd1);

    // Full vector 1,2,3,4
    beat(4'd1, 1'b0, 1'b0); chk("full_b1_nv", 32'(o_valid), 32'd0);
    beat(4'd2, 1'b0, 1'b0); chk("full_b2_nv", 32'(o_valid), 32'd0);
    beat(4'd3, 1'b0, 1'b0); chk("full_b3_nv", 32'(o_valid), 32'd0);
    beat(4'd4, 1'b0, 1'b0);
    chk("full_o_valid", 32'(o_valid), 32'd1);
    chk("full_o_data",  32'(o_data),  32'h4321);
    chk("full_o_count", 32'(o_count), 32'd4);
    chk("full_o_last",  32'(o_last),  32'd0);
    chk("full_vec_cnt", 32'(vec_cnt), 32'd1);
    idle(1'b0);
    chk("full_pulse_end", 32'(o_valid), 32'd0);
    chk("full_data_hold", 32'(o_data),  32'h4321);

    // s_last partial 5,6
    beat(4'd5, 1'b0, 1'b0); chk("slast_b1_nv", 32'(o_valid), 32'd0);
    beat(4'd6, 1'b1, 1'b0);
    chk("slast_o_valid", 32'(o_valid), 32'd1);
    chk("slast_o_data",  32'(o_data),  32'h0065);
    chk("slast_o_count", 32'(o_count), 32'd2);
    chk("slast_o_last",  32'(o_last),  32'd1);
    chk("slast_sum",     tree_sum(o_data), 32'd11);
    chk("slast_vec_cnt", 32'(vec_cnt), 32'd2);

    // Lone flush after beat 7
    beat(4'd7, 1'b0, 1'b0);
    idle(1'b0);
    chk("flush_idle_nv", 32'(o_valid), 32'd0);
    idle(1'b1);
    chk("flush_o_valid", 32'(o_valid), 32'd1);
    chk("flush_o_data",  32'(o_data),  32'h0007);
    chk("flush_o_count", 32'(o_count), 32'd1);
    chk("flush_o_last",  32'(o_last),  32'd0);
    chk("flush_vec_cnt", 32'(vec_cnt), 32'd3);
    idle(1'b1);
    chk("flush_empty_nv",  32'(o_valid), 32'd0);
    chk("flush_empty_cnt", 32'(vec_cnt), 32'd3);

    // Back-to-back streaming 0..11
    emits = 0;
    for (int k = 0; k < 12; k++) begin
      chk("stream_s_ready", 32'(s_ready), 32'd1);
      beat(DW'(k), 1'b0, 1'b0);
      chk("stream_o_valid", 32'(o_valid), (k % 4 == 3) ? 32'd1 : 32'd0);
      if (k == 3)  chk("stream_sum0", tree_sum(o_data), 32'd6);
      if (k == 7)  chk("stream_sum1", tree_sum(o_data), 32'd22);
      if (k == 11) chk("stream_sum2", tree_sum(o_data), 32'd38);
      if (o_valid) emits++;
    end
    chk("stream_emits",  emits,          32'd3);
    chk("stream_vec_cnt", 32'(vec_cnt),  32'd6);

    // flush + s_last on the 4th beat
    beat(4'd1, 1'b0, 1'b0);
    beat(4'd2, 1'b0, 1'b0);
    beat(4'd3, 1'b0, 1'b0);
    beat(4'd4, 1'b1, 1'b1);
    chk("simul_o_valid", 32'(o_valid), 32'd1);
    chk("simul_o_count", 32'(o_count), 32'd4);
    chk("simul_o_last",  32'(o_last),  32'd1);
    chk("simul_o_data",  32'(o_data),  32'h4321);
    chk("simul_vec_cnt", 32'(vec_cnt), 32'd7);
    idle(1'b0);
    chk("simul_single",  32'(o_valid), 32'd0);
    chk("simul_vec_cnt2", 32'(vec_cnt), 32'd7);

    // Reset mid-fill
    beat(4'd9, 1'b0, 1'b0);
    beat(4'hA, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1'b0);
    chk("midrst_o_valid", 32'(o_valid), 32'd0);
    chk("midrst_o_data",  32'(o_data),  32'd0);
    chk("midrst_o_count", 32'(o_count), 32'd0);
    chk("midrst_vec_cnt", 32'(vec_cnt), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    rst = 1'b1;
    idle(1'b0);
    chk("midrst_no_emit", 32'(o_valid), 32'd0);
    beat(4'd1, 1'b0, 1'b0);
    beat(4'd2, 1'b0, 1'b0);
    beat(4'd3, 1'b0, 1'b0);
    chk("post_rst_nv", 32'(o_valid), 32'd0);
    beat(4'd4, 1'b0, 1'b0);
    chk("post_rst_o_valid", 32'(o_valid),   32'd1);
    chk("post_rst_o_count", 32'(o_count),   32'd4);
    chk("post_rst_lane0",   32'(o_data[0]), 32'd1);
    chk("post_rst_o_data",  32'(o_data),    32'h4321);
    chk("post_rst_vec_cnt", 32'(vec_cnt),   32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
